// File: rtl/map_compose_pkg.sv
// Shared game parameters for the tile-map compositor: tile id constants,
// fog settings, map stride and the pass FSM encoding.
package map_compose_pkg;

    localparam logic [15:0] RS_EMPTY = 16'h0000;
    localparam logic [15:0] RS_WALL  = 16'h0001;
    localparam logic [15:0] RS_FOG   = 16'h00FF;

    localparam logic [15:0] FOG_TILE   = RS_FOG;
    localparam int          FOG_RADIUS = 3;

    localparam int MAP_SHIFT_DEF = 8;
    localparam int MAP_STRIDE    = 1 << MAP_SHIFT_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } map_state_e;

    // Unsigned distance between two grid coordinates.
    function automatic logic [3:0] abs_diff4(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/map_overlay_sel.sv
// Combinational entity overlay: the lowest enabled slot whose position equals
// the current cell supplies the tile id.
module map_overlay_sel
    import map_compose_pkg::*;
#(
    parameter int N_ENT = 4,
    parameter int ID_W  = 16,
    parameter int MAP_W = 13,
    parameter int MAP_H = 13
) (
    input  logic [N_ENT-1:0]      en_i,
    input  logic [N_ENT*4-1:0]    x_i,
    input  logic [N_ENT*4-1:0]    y_i,
    input  logic [N_ENT*ID_W-1:0] tile_i,
    input  logic [3:0]            gx_i,
    input  logic [3:0]            gy_i,
    output logic                  hit_o,
    output logic [ID_W-1:0]       tile_o
);

    logic [N_ENT-1:0] match_s;

    // Slots parked outside the grid can never match a cell.
    for (genvar i = 0; i < N_ENT; i++) begin : g_match
        assign match_s[i] = en_i[i]
                          && ({1'b0, x_i[4*i +: 4]} < 5'(MAP_W))
                          && ({1'b0, y_i[4*i +: 4]} < 5'(MAP_H))
                          && (x_i[4*i +: 4] == gx_i)
                          && (y_i[4*i +: 4] == gy_i);
    end

    assign hit_o = |match_s;

    // Scan from the highest slot down so the lowest matching slot is written last.
    always_comb begin
        tile_o = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            tile_o = match_s[i] ? tile_i[ID_W*i +: ID_W] : tile_o;
        end
    end

endmodule

// File: rtl/map_compose.sv
// Tile-map compositor: raster walk of the map, BRAM fetch, entity overlay and
// valid/ready hand-off to the blitter. Optional fog of war under MAP_FOG_EN.
module map_compose
    import map_compose_pkg::*;
#(
    parameter int MAP_W     = 13,
    parameter int MAP_H     = 13,
    parameter int N_ENT     = 4,
    parameter int ID_W      = 16,
    parameter int MAP_ID_W  = 16,
    parameter int ADDR_W    = 19,
    parameter int MAP_SHIFT = MAP_SHIFT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MAP_ID_W-1:0]   map_id,
    input  logic [N_ENT-1:0]      ent_en,
    input  logic [N_ENT*4-1:0]    ent_x,
    input  logic [N_ENT*4-1:0]    ent_y,
    input  logic [N_ENT*ID_W-1:0] ent_tile,
    input  logic [3:0]            fog_cx,
    input  logic [3:0]            fog_cy,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     map_addr,
    output logic                  map_rd,
    input  logic [ID_W-1:0]       map_data,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic [ID_W-1:0]       tile_id,
    output logic [3:0]            tile_gx,
    output logic [3:0]            tile_gy
);

    localparam int SUM_W = MAP_ID_W + MAP_SHIFT + 10;

    map_state_e              state_q;
    logic                    busy_q, done_q, map_rd_q, tile_valid_q;
    logic [ADDR_W-1:0]       map_addr_q;
    logic [ID_W-1:0]         tile_id_q;
    logic [3:0]              tile_gx_q, tile_gy_q;
    logic [3:0]              gx_q, gy_q;
    logic [MAP_ID_W-1:0]     map_id_q;
    logic [N_ENT-1:0]        ent_en_q;
    logic [N_ENT*4-1:0]      ent_x_q, ent_y_q;
    logic [N_ENT*ID_W-1:0]   ent_tile_q;

    logic [3:0]              gx_d, gy_d;
    logic                    last_cell_s;
    logic                    ovl_hit_s;
    logic [ID_W-1:0]         ovl_tile_s;
    logic [ID_W-1:0]         pre_tile_s;
    logic [ID_W-1:0]         res_tile_s;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [MAP_ID_W-1:0] mid,
                                                    input logic [3:0] cx,
                                                    input logic [3:0] cy);
        logic [SUM_W-1:0] sum;
        sum = (SUM_W'(mid) << MAP_SHIFT) + SUM_W'(cy) * SUM_W'(MAP_W) + SUM_W'(cx);
        return ADDR_W'(sum);
    endfunction

    // Next raster position and end-of-pass detection.
    always_comb begin
        last_cell_s = (gx_q == 4'(MAP_W - 1)) && (gy_q == 4'(MAP_H - 1));
        if (gx_q == 4'(MAP_W - 1)) begin
            gx_d = 4'd0;
            gy_d = gy_q + 4'd1;
        end else begin
            gx_d = gx_q + 4'd1;
            gy_d = gy_q;
        end
    end

    map_overlay_sel #(
        .N_ENT (N_ENT),
        .ID_W  (ID_W),
        .MAP_W (MAP_W),
        .MAP_H (MAP_H)
    ) u_overlay (
        .en_i   (ent_en_q),
        .x_i    (ent_x_q),
        .y_i    (ent_y_q),
        .tile_i (ent_tile_q),
        .gx_i   (gx_q),
        .gy_i   (gy_q),
        .hit_o  (ovl_hit_s),
        .tile_o (ovl_tile_s)
    );

    assign pre_tile_s = ovl_hit_s ? ovl_tile_s : map_data;

`ifdef MAP_FOG_EN
    logic [3:0] fog_cx_q, fog_cy_q;
    logic [3:0] fog_dx_s, fog_dy_s, fog_dmax_s;
    logic       fog_far_s;

    // Fog centre is frozen for the whole pass, like the entity table.
    always_ff @(posedge clk) begin
        if (rst) begin
            fog_cx_q <= 4'd0;
            fog_cy_q <= 4'd0;
        end else if (state_q == ST_IDLE && start) begin
            fog_cx_q <= fog_cx;
            fog_cy_q <= fog_cy;
        end
    end

    assign fog_dx_s   = abs_diff4(gx_q, fog_cx_q);
    assign fog_dy_s   = abs_diff4(gy_q, fog_cy_q);
    assign fog_dmax_s = (fog_dx_s > fog_dy_s) ? fog_dx_s : fog_dy_s;
    assign fog_far_s  = fog_dmax_s > 4'(FOG_RADIUS);
    // Fog is applied after overlay so entities in the dark stay hidden.
    assign res_tile_s = fog_far_s ? ID_W'(FOG_TILE) : pre_tile_s;
`else
    logic unused_fog_s;
    assign unused_fog_s = ^{fog_cx, fog_cy};
    assign res_tile_s   = pre_tile_s;
`endif

    // Pass sequencer; every output is a register updated on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            map_rd_q     <= 1'b0;
            tile_valid_q <= 1'b0;
            map_addr_q   <= '0;
            tile_id_q    <= '0;
            tile_gx_q    <= 4'd0;
            tile_gy_q    <= 4'd0;
            gx_q         <= 4'd0;
            gy_q         <= 4'd0;
            map_id_q     <= '0;
            ent_en_q     <= '0;
            ent_x_q      <= '0;
            ent_y_q      <= '0;
            ent_tile_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        map_id_q   <= map_id;
                        ent_en_q   <= ent_en;
                        ent_x_q    <= ent_x;
                        ent_y_q    <= ent_y;
                        ent_tile_q <= ent_tile;
                        gx_q       <= 4'd0;
                        gy_q       <= 4'd0;
                        map_addr_q <= cell_addr(map_id, 4'd0, 4'd0);
                        map_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    map_rd_q <= 1'b0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    tile_id_q    <= res_tile_s;
                    tile_gx_q    <= gx_q;
                    tile_gy_q    <= gy_q;
                    tile_valid_q <= 1'b1;
                    state_q      <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (tile_ready) begin
                        tile_valid_q <= 1'b0;
                        if (last_cell_s) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            gx_q       <= gx_d;
                            gy_q       <= gy_d;
                            map_addr_q <= cell_addr(map_id_q, gx_d, gy_d);
                            map_rd_q   <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    map_rd_q     <= 1'b0;
                    tile_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign map_addr   = map_addr_q;
    assign map_rd     = map_rd_q;
    assign tile_valid = tile_valid_q;
    assign tile_id    = tile_id_q;
    assign tile_gx    = tile_gx_q;
    assign tile_gy    = tile_gy_q;

endmodule

// File: tb/tb_map_compose.sv
// Scoreboard bench for map_compose: BRAM model, per-pass expectation queues,
// stall / ignored-start / mid-pass reset scenarios, fog pass under MAP_FOG_EN.
module tb_map_compose;
    import map_compose_pkg::*;

`ifdef MAP_FOG_EN
    localparam int W = 6;
    localparam int H = 6;
`else
    localparam int W = 4;
    localparam int H = 4;
`endif
    localparam int NE  = 4;
    localparam int IDW = 16;
    localparam int MIW = 16;
    localparam int AW  = 19;
    localparam int SH  = 8;

    logic               clk = 1'b0;
    logic               rst, start, tile_ready;
    logic [MIW-1:0]     map_id;
    logic [NE-1:0]      ent_en;
    logic [NE*4-1:0]    ent_x, ent_y;
    logic [NE*IDW-1:0]  ent_tile;
    logic [3:0]         fog_cx, fog_cy;
    logic               busy, done, map_rd, tile_valid;
    logic [AW-1:0]      map_addr;
    logic [IDW-1:0]     map_data = '0;
    logic [IDW-1:0]     tile_id;
    logic [3:0]         tile_gx, tile_gy;

    map_compose #(
        .MAP_W(W), .MAP_H(H), .N_ENT(NE), .ID_W(IDW),
        .MAP_ID_W(MIW), .ADDR_W(AW), .MAP_SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .map_id(map_id),
        .ent_en(ent_en), .ent_x(ent_x), .ent_y(ent_y), .ent_tile(ent_tile),
        .fog_cx(fog_cx), .fog_cy(fog_cy), .busy(busy), .done(done),
        .map_addr(map_addr), .map_rd(map_rd), .map_data(map_data),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_id(tile_id),
        .tile_gx(tile_gx), .tile_gy(tile_gy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [AW-1:0] a);
        return 16'(a) ^ 16'h5A3C;
    endfunction

    // BRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (map_rd) map_data <= mem_f(map_addr);
    end

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  gx;
        logic [3:0]  gy;
    } tile_t;

    tile_t          exp_tq[$];
    logic [AW-1:0]  exp_aq[$];
    int             n_chk = 0;
    int             n_pass = 0;
    int             done_cnt = 0;
    bit             last_hs = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [AW-1:0] exp_addr(input logic [MIW-1:0] mid, input int x, input int y);
        logic [31:0] wide;
        wide = (32'(mid) << SH) + 32'(y * W + x);
        return wide[AW-1:0];
    endfunction

    task automatic push_pass(input logic [MIW-1:0] mid, input logic [NE-1:0] en,
                             input logic [NE*4-1:0] ex, input logic [NE*4-1:0] ey,
                             input logic [NE*IDW-1:0] et, input logic [3:0] cx, input logic [3:0] cy);
        tile_t t;
        logic [AW-1:0] a;
        int dx, dy;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                a = exp_addr(mid, x, y);
                exp_aq.push_back(a);
                t.id = mem_f(a);
                t.gx = 4'(x);
                t.gy = 4'(y);
                for (int s = NE - 1; s >= 0; s--) begin
                    if (en[s] && int'(ex[4*s +: 4]) == x && int'(ey[4*s +: 4]) == y)
                        t.id = et[IDW*s +: IDW];
                end
                dx = (x > int'(cx)) ? x - int'(cx) : int'(cx) - x;
                dy = (y > int'(cy)) ? y - int'(cy) : int'(cy) - y;
`ifdef MAP_FOG_EN
                if (((dx > dy) ? dx : dy) > FOG_RADIUS) t.id = FOG_TILE;
`endif
                exp_tq.push_back(t);
            end
        end
    endtask

    task automatic start_pass(input logic [MIW-1:0] mid, input logic [NE-1:0] en,
                              input logic [NE*4-1:0] ex, input logic [NE*4-1:0] ey,
                              input logic [NE*IDW-1:0] et, input logic [3:0] cx, input logic [3:0] cy);
        @(posedge clk); #1;
        map_id = mid; ent_en = en; ent_x = ex; ent_y = ey; ent_tile = et;
        fog_cx = cx; fog_cy = cy; start = 1'b1;
        push_pass(mid, en, ex, ey, et, cx, cy);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check_val("pass_done", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    // Monitor: address and tile scoreboards, done placement
    always @(negedge clk) begin
        tile_t t;
        logic [AW-1:0] a;
        if (!rst) begin
            if (done) begin
                done_cnt++;
                check_val("done_after_last", 32'(last_hs), 32'd1);
                check_val("done_queue_empty", 32'(exp_tq.size()), 32'd0);
            end
            last_hs = 1'b0;
            if (map_rd) begin
                if (exp_aq.size() == 0) begin
                    check_val("addr_extra_read", 32'(exp_aq.size()), 32'd1);
                end else begin
                    a = exp_aq.pop_front();
                    check_val("map_addr", 32'(map_addr), 32'(a));
                end
            end
            if (tile_valid && tile_ready) begin
                if (exp_tq.size() == 0) begin
                    check_val("tile_extra", 32'(exp_tq.size()), 32'd1);
                end else begin
                    t = exp_tq.pop_front();
                    check_val("tile_id", 32'(tile_id), 32'(t.id));
                    check_val("tile_gx", 32'(tile_gx), 32'(t.gx));
                    check_val("tile_gy", 32'(tile_gy), 32'(t.gy));
                    last_hs = (exp_tq.size() == 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired n_pass=%0d n_chk=%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int d0;
        bit seen;
        logic [AW-1:0] base;
        rst = 1'b1; start = 1'b0; tile_ready = 1'b1;
        map_id = '0; ent_en = '0; ent_x = '0; ent_y = '0; ent_tile = '0;
        fog_cx = 4'd0; fog_cy = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_map_rd", 32'(map_rd), 32'd0);
        check_val("rst_valid", 32'(tile_valid), 32'd0);
        check_val("rst_addr", 32'(map_addr), 32'd0);
        check_val("rst_tile_id", 32'(tile_id), 32'd0);
        check_val("rst_gx", 32'(tile_gx), 32'd0);
        check_val("rst_gy", 32'(tile_gy), 32'd0);
        rst = 1'b0;

        // Plain pass on map 2, latency to first tile
        start_pass(16'd2, 4'b0000, '0, '0, '0, 4'd0, 4'd0);
        check_val("lat_busy", 32'(busy), 32'd1);
        check_val("lat_valid_c1", 32'(tile_valid), 32'd0);
        @(posedge clk); #1;
        check_val("lat_valid_c2", 32'(tile_valid), 32'd0);
        @(posedge clk); #1;
        check_val("lat_valid_c3", 32'(tile_valid), 32'd1);
        wait_done(3 * W * H + 20);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("done_count_1", 32'(done_cnt), 32'd1);

        // Overlay priority: slots 0 and 2 on (1,1), slot 1 off-grid, slot 3 disabled
        start_pass(16'd2, 4'b0111, {4'd2, 4'd1, 4'd9, 4'd1}, {4'd2, 4'd1, 4'd9, 4'd1},
                   {16'h00CC, 16'h00A2, 16'h00BB, 16'h00A0}, 4'd0, 4'd0);
        wait_done(3 * W * H + 20);
        start_pass(16'd2, 4'b0110, {4'd2, 4'd1, 4'd9, 4'd1}, {4'd2, 4'd1, 4'd9, 4'd1},
                   {16'h00CC, 16'h00A2, 16'h00BB, 16'h00A0}, 4'd0, 4'd0);
        wait_done(3 * W * H + 20);

        // Back-pressure on cell 5
        start_pass(16'd3, 4'b0000, '0, '0, '0, 4'd0, 4'd0);
        base = exp_addr(16'd3, 5 % W, 5 / W);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (map_rd && map_addr == base) seen = 1'b1;
        end
        check_val("stall_cell5_fetch", 32'(seen), 32'd1);
        #1 tile_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (tile_valid) seen = 1'b1;
        end
        check_val("stall_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("stall_valid", 32'(tile_valid), 32'd1);
            check_val("stall_id", 32'(tile_id), 32'(mem_f(base)));
            check_val("stall_gx", 32'(tile_gx), 32'(5 % W));
            check_val("stall_gy", 32'(tile_gy), 32'(5 / W));
            check_val("stall_no_rd", 32'(map_rd), 32'd0);
        end
        tile_ready = 1'b1;
        wait_done(3 * W * H + 20);

        // Start during a pass is ignored
        start_pass(16'd2, 4'b0000, '0, '0, '0, 4'd0, 4'd0);
        d0 = done_cnt;
        repeat (7) @(posedge clk);
        #1;
        map_id = 16'd7; ent_en = 4'b1111; ent_x = '0; ent_y = '0; ent_tile = {4{16'hDEAD}};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3 * W * H + 20);
        repeat (3) @(posedge clk);
        #1;
        check_val("single_done", 32'(done_cnt), 32'(d0 + 1));
        check_val("no_extra_addr", 32'(exp_aq.size()), 32'd0);
        check_val("idle_after_ignored", 32'(busy), 32'd0);

        // Reset while cell 3 is presented
        start_pass(16'd2, 4'b0000, '0, '0, '0, 4'd0, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (tile_valid && tile_gx == 4'd3 && tile_gy == 4'd0) seen = 1'b1;
        end
        check_val("rst_cell3_seen", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_map_rd", 32'(map_rd), 32'd0);
        check_val("abort_valid", 32'(tile_valid), 32'd0);
        check_val("abort_addr", 32'(map_addr), 32'd0);
        check_val("abort_tile_id", 32'(tile_id), 32'd0);
        check_val("abort_gx", 32'(tile_gx), 32'd0);
        check_val("abort_gy", 32'(tile_gy), 32'd0);
        exp_aq.delete();
        exp_tq.delete();
        rst = 1'b0;
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        check_val("abort_no_done", 32'(done_cnt), 32'(d0));
        check_val("abort_idle", 32'(busy), 32'd0);
        start_pass(16'd4, 4'b0000, '0, '0, '0, 4'd0, 4'd0);
        wait_done(3 * W * H + 20);

`ifdef MAP_FOG_EN
        // Fog centred at (0,0): far cells and the entity at (5,5) are fogged
        start_pass(16'd1, 4'b0001, {12'd0, 4'd5}, {12'd0, 4'd5},
                   {48'd0, 16'h00E5}, 4'd0, 4'd0);
        wait_done(3 * W * H + 20);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
